// File: rtl/lenet_pkg.sv
// lenet_pkg: constants and helpers shared by the LeNet-5 datapath stages.
//   DATA_W   - width of a signed feature-map sample
//   *_LEN    - square feature-map edge lengths of layers C1, S2, C3, S4
//   sample_t - signed sample type
//   max2     - signed maximum of two samples
package lenet_pkg;

  localparam int DATA_W = 16;

  localparam int C1_LEN = 28;
  localparam int S2_LEN = 14;
  localparam int C3_LEN = 10;
  localparam int S4_LEN = 5;

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic sample_t max2(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: simple dual-port line buffer for pooling stages.
// Holds one row's worth of horizontal pair maxima.
// Ports:
//   clk     - clock
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - write data
//   rd_en   - read strobe; rd_data updates only when high
//   rd_addr - read address
//   rd_data - registered read data (old contents on a same-address write)
// No reset: every entry is written before it is read.
module pool_line_buf #(
  parameter int DEPTH  = 14,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 stride-2 max pooling (LeNet-5 S2).
// Consumes one row-major sample per cycle while en is high and emits one
// pooled maximum per 2x2 window, one cycle after the window's last sample.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   en         - din valid / accept this cycle
//   din        - signed input sample
//   dout       - signed pooled maximum (held between pulses)
//   dout_valid - one-cycle pulse, dout valid
//   frame_done - pulse coincident with the last dout_valid of a frame
//   busy       - high from first accepted sample of a frame until frame_done
module maxpool2x2_stream
  import lenet_pkg::*;
#(
  parameter int DATA_W  = lenet_pkg::DATA_W,
  parameter int IN_COLS = lenet_pkg::C1_LEN,
  parameter int IN_ROWS = lenet_pkg::C1_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int COL_W     = $clog2(IN_COLS);
  localparam int ROW_W     = $clog2(IN_ROWS);
  localparam int BUF_DEPTH = IN_COLS / 2;
  localparam int ADDR_W    = $clog2(BUF_DEPTH);

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [COL_W-1:0]         col_reg;
  logic [ROW_W-1:0]         row_reg;
  logic signed [DATA_W-1:0] pair_reg;
  logic signed [DATA_W-1:0] dout_reg;
  logic                     valid_reg;
  logic                     done_reg;
  logic                     busy_reg;

  logic                     col_last;
  logic                     row_last;
  logic                     buf_wr;
  logic                     emit;
  logic                     last;
  logic [ADDR_W-1:0]        buf_addr;
  logic [DATA_W-1:0]        line_rd;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] win_max;

  assign col_last = (col_reg == COL_W'(IN_COLS - 1));
  assign row_last = (row_reg == ROW_W'(IN_ROWS - 1));
  assign buf_addr = ADDR_W'(col_reg >> 1);

  assign pair_max = smax(pair_reg, $signed(din));
  assign win_max  = smax($signed(line_rd), pair_max);

  assign buf_wr = en && col_reg[0] && !row_reg[0];
  assign emit   = en && col_reg[0] && row_reg[0];
  assign last   = emit && row_last && col_last;

  // The read port is strobed by en, so the even-column sample of an odd row
  // fetches line_buf[col>>1] and it is held, across any en gap, until the
  // matching odd-column sample arrives. This keeps a registered read without
  // adding output latency.
  pool_line_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_W),
    .ADDR_W(ADDR_W)
  ) u_line_buf (
    .clk    (clk),
    .wr_en  (buf_wr),
    .wr_addr(buf_addr),
    .wr_data(pair_max),
    .rd_en  (en),
    .rd_addr(buf_addr),
    .rd_data(line_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_reg   <= '0;
      row_reg   <= '0;
      pair_reg  <= '0;
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      valid_reg <= emit;
      done_reg  <= last;

      if (en) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end

        if (!col_reg[0]) begin
          pair_reg <= $signed(din);
        end

        if (emit) begin
          dout_reg <= win_max;
        end
      end

      // Frame end wins; a frame start can never coincide with it.
      if (last) begin
        busy_reg <= 1'b0;
      end else if (en && col_reg == '0 && row_reg == '0) begin
        busy_reg <= 1'b1;
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = valid_reg;
  assign frame_done = done_reg;
  assign busy       = busy_reg;

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2 stride-2 max-pooling stage (layer S2) for the LeNet-5 datapath.
- Sits directly downstream of the layer controller. It consumes one C1 feature-map value per cycle whenever the controller's S2 enable is high.
- Buffers half a row of pair-maxima and emits one pooled value per 2x2 window.
- Output is 14x14 pooled values per 28x28 C1 channel frame, fed to C3.

Parameters:
- DATA_W, 16, width of signed input/output samples (two's complement).
- IN_COLS, 28, C1 row length; must be even.
- IN_ROWS, 28, C1 rows per frame; must be even.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  S2 read enable from controller; din valid this cycle
- din  input  DATA_W  signed C1 output sample, row-major order
- dout  output  DATA_W  signed pooled maximum
- dout_valid  output  1  one-cycle pulse, dout valid
- frame_done  output  1  one-cycle pulse coincident with last dout_valid of frame
- busy  output  1  high from first accepted sample of a frame until frame_done

Behaviour:
- Reset (rst_n low at posedge):
  - dout=0, dout_valid=0, frame_done=0, busy=0.
  - col counter=0, row counter=0, pair register=0.
  - Line buffer contents are don't-care; they are always written before being read.
  - Reset mid-frame abandons the partial frame. No output pulse for it.
- en low: no state change. Counters, pair register and line buffer hold. dout_valid=0 and frame_done=0 next cycle.
- en high, sample accepted:
  - col advances 0..IN_COLS-1 and wraps to 0.
  - On wrap, row advances 0..IN_ROWS-1 and wraps to 0.
- Even column (col[0]=0): pair register <= din.
- Odd column (col[0]=1): pm = signed max(pair register, din).
  - Even row: line_buf[col>>1] <= pm. No output.
  - Odd row: dout <= signed max(line_buf[col>>1], pm) and dout_valid <= 1, both registered.
- Latency: dout_valid asserts exactly 1 cycle after the accepted sample at (odd row, odd col).
- Comparison is signed, full DATA_W. Ties select either operand (value identical). No saturation needed.
- frame_done <= 1 on the same edge as dout_valid when row=IN_ROWS-1 and col=IN_COLS-1. Counters wrap to (0,0) and the next frame starts seamlessly.
- busy: set on the first accepted sample with row=col=0; cleared on the edge that raises frame_done. If a new frame's first sample arrives the cycle after frame_done, busy re-asserts.
- Gaps in en (including the controller's 4-cycle row skip) are arbitrary and are transparent to the data path.
- Outputs per frame: (IN_ROWS/2)*(IN_COLS/2) = 196 at default.
- Counter widths: $clog2(IN_COLS) and $clog2(IN_ROWS).
- Line buffer: IN_COLS/2 entries x DATA_W. One write port and one read port, same address. Read is combinational or registered, at implementer's choice, but dout latency must stay 1.

Decomposition:
- Shared package lenet_pkg holds:
  - DATA_W
  - C1_LEN=28, S2_LEN=14, C3_LEN=10, S4_LEN=5
  - a signed sample typedef
  - a max2 function
- One sub-module: pool_line_buf (parameterised depth/width, single write port and single read port), reusable by the S4 stage with depth C3_LEN/2.

Test Plan:
- Ramp frame, en always 1, din = row*28+col → 196 pulses, first dout=29 one cycle after sample (1,1), last dout=783 with frame_done.
- Negative data: din = -(row*28+col) - 1 → first dout=-1, every output equals top-left value of its window; confirms signed compare.
- Controller gapping: en high 28 cycles, low 4, repeated → outputs identical to the ramp case. dout_valid is never high in the cycle after an en-low cycle.
- Random en (50%) with random din, checked against a golden 2x2 max model → 196 outputs, exact match, order preserved.
- rst_n low after 100 accepted samples, then a full fresh ramp frame → no outputs during reset, busy=0. The fresh frame yields exactly 196 correct outputs with no stale line-buffer data.
- Two back-to-back frames without a gap → frame_done pulses twice, 392 outputs total. Second frame's first dout appears 1 cycle after its sample (1,1).
